// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the register file slice.
//   DEFAULT_DATA_W - default register width in bits
//   DEFAULT_ADDR_W - default address width
//   depth_of()     - number of registers for a given address width
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// regfile_sb_if: bundles the decode/writeback side signals of regfile_sb.
//   master - decode/writeback side: drives D port, read addresses, reservations, flush
//   slave  - register file side: returns read data, busy flags and busy count
//
// There is no valid/ready pairing here: every request is a single-cycle strobe
// that is always accepted. D_En qualifies D_Addr/D on the clock edge, rsv_en
// qualifies rsv_addr, sb_flush is a one-cycle clear; S/T and the busy outputs
// are combinational responses to the addresses presented in the same cycle.
interface regfile_sb_if #(
    parameter int DATA_W = regfile_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = regfile_pkg::DEFAULT_ADDR_W
) ();

    logic              D_En;
    logic [ADDR_W-1:0] D_Addr;
    logic [DATA_W-1:0] D;
    logic [ADDR_W-1:0] S_Addr;
    logic [ADDR_W-1:0] T_Addr;
    logic [DATA_W-1:0] S;
    logic [DATA_W-1:0] T;
    logic              rsv_en;
    logic [ADDR_W-1:0] rsv_addr;
    logic              sb_flush;
    logic              S_busy;
    logic              T_busy;
    logic              hazard;
    logic [ADDR_W:0]   busy_cnt;

    modport master (
        output D_En, D_Addr, D, S_Addr, T_Addr, rsv_en, rsv_addr, sb_flush,
        input  S, T, S_busy, T_busy, hazard, busy_cnt
    );

    modport slave (
        input  D_En, D_Addr, D, S_Addr, T_Addr, rsv_en, rsv_addr, sb_flush,
        output S, T, S_busy, T_busy, hazard, busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register busy bits plus a running count of busy registers.
//   clk, reset         - clock, asynchronous active-high reset
//   flush              - clear every busy bit (dominates clear and reserve)
//   clr_en, clr_addr   - writeback completion, clears the bit
//   rsv_en, rsv_addr   - decode reservation, sets the bit (wins over a same-address clear)
//   busy               - busy vector, bit 0 is never set
//   busy_cnt           - popcount of busy, maintained incrementally
module regfile_scoreboard #(
    parameter int ADDR_W = regfile_pkg::DEFAULT_ADDR_W,
    parameter int DEPTH  = regfile_pkg::depth_of(ADDR_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              clr_en,
    input  logic [ADDR_W-1:0] clr_addr,
    input  logic              rsv_en,
    input  logic [ADDR_W-1:0] rsv_addr,
    output logic [DEPTH-1:0]  busy,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int CNT_W = ADDR_W + 1;

    logic             set_bit;
    logic             clr_bit;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [DEPTH-1:0] busy_next;

    always_comb begin
        set_bit   = rsv_en && (rsv_addr != '0);
        clr_bit   = clr_en && (clr_addr != '0);
        busy_next = busy;
        if (clr_bit) busy_next[clr_addr] = 1'b0;
        // Applied after the clear so a same-address reservation (newer producer) wins.
        if (set_bit) busy_next[rsv_addr] = 1'b1;
        // Net change of the count: a newly set bit adds one, a cleared bit subtracts
        // one unless the same bit is re-reserved in this cycle.
        cnt_inc = set_bit && !busy[rsv_addr];
        cnt_dec = clr_bit && busy[clr_addr] && !(set_bit && (rsv_addr == clr_addr));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else if (flush) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_next;
            case ({cnt_inc, cnt_dec})
                2'b10:   busy_cnt <= busy_cnt + CNT_W'(1);
                2'b01:   busy_cnt <= busy_cnt - CNT_W'(1);
                default: busy_cnt <= busy_cnt;
            endcase
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 1-write register file with optional write-to-read bypass
// and a busy scoreboard for read-after-write hazard detection.
//   clk, reset - clock, asynchronous active-high reset (clears data and busy state)
//   bus        - regfile_sb_if slave: D write port, S/T read ports, reservation,
//                flush, S_busy/T_busy/hazard and busy_cnt
// Parameters: DATA_W, ADDR_W, BYPASS (1 = forward same-cycle write data to S/T).
module regfile_sb #(
    parameter int DATA_W = regfile_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = regfile_pkg::DEFAULT_ADDR_W,
    parameter int BYPASS = 1
) (
    input logic         clk,
    input logic         reset,
    regfile_sb_if.slave bus
);

    import regfile_pkg::*;

    localparam int DEPTH = depth_of(ADDR_W);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic              s_fwd;
    logic              t_fwd;

    // Register 0 is never written, so mem[0] stays at its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (bus.D_En && (bus.D_Addr != '0)) begin
            mem[bus.D_Addr] <= bus.D;
        end
    end

    // A port forwards when the write in flight this cycle targets its nonzero address.
    always_comb begin
        s_fwd = (BYPASS != 0) && bus.D_En && (bus.D_Addr == bus.S_Addr) && (bus.S_Addr != '0);
        t_fwd = (BYPASS != 0) && bus.D_En && (bus.D_Addr == bus.T_Addr) && (bus.T_Addr != '0);
    end

    always_comb begin
        bus.S = '0;
        if (s_fwd)                    bus.S = bus.D;
        else if (bus.S_Addr != '0)    bus.S = mem[bus.S_Addr];
        bus.T = '0;
        if (t_fwd)                    bus.T = bus.D;
        else if (bus.T_Addr != '0)    bus.T = mem[bus.T_Addr];
    end

    regfile_scoreboard #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_scoreboard (
        .clk      (clk),
        .reset    (reset),
        .flush    (bus.sb_flush),
        .clr_en   (bus.D_En),
        .clr_addr (bus.D_Addr),
        .rsv_en   (bus.rsv_en),
        .rsv_addr (bus.rsv_addr),
        .busy     (busy),
        .busy_cnt (bus.busy_cnt)
    );

    // A forwarded operand is no longer a hazard even though its bit clears only at the edge.
    always_comb begin
        bus.S_busy = busy[bus.S_Addr] && (bus.S_Addr != '0) && !s_fwd;
        bus.T_busy = busy[bus.T_Addr] && (bus.T_Addr != '0) && !t_fwd;
        bus.hazard = bus.S_busy || bus.T_busy;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised, generalised register file for the single-cycle/pipelined CPU datapath: two combinational read ports (S, T), one write port (D), register 0 hard-wired to zero, full clear on reset. Adds a write-to-read bypass and a per-register busy scoreboard, so the decode stage can detect read-after-write hazards against in-flight producers. Sits between the instruction decoder (reads, reservations) and the writeback stage (D port).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- BYPASS, 1, 1 = same-cycle write data forwarded to S/T; 0 = no forwarding

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- D_En  in  1  write enable
- D_Addr  in  ADDR_W  write address
- D  in  DATA_W  write data
- S_Addr  in  ADDR_W  read port S address
- T_Addr  in  ADDR_W  read port T address
- S  out  DATA_W  read data S
- T  out  DATA_W  read data T
- rsv_en  in  1  reserve (mark busy) request from decode
- rsv_addr  in  ADDR_W  register being reserved
- sb_flush  in  1  synchronous clear of all busy bits (pipeline flush)
- S_busy  out  1  S_Addr has an outstanding producer
- T_busy  out  1  T_Addr has an outstanding producer
- hazard  out  1  S_busy | T_busy
- busy_cnt  out  ADDR_W+1  number of busy registers

## Operation
- Storage: 2**ADDR_W x DATA_W array; busy vector of 2**ADDR_W bits; busy_cnt register.
- Reset: every register, every busy bit and busy_cnt cleared to 0. Outputs after reset: S = T = 0, S_busy = T_busy = hazard = 0, busy_cnt = 0.
- Write: on posedge clk, if D_En and D_Addr != 0, array[D_Addr] <= D. Writes to address 0 are dropped; array[0] reads 0 always.
- Read: S = array[S_Addr], T = array[T_Addr], combinational. Address 0 returns 0 regardless of BYPASS.
- Bypass (BYPASS=1): if D_En and D_Addr == S_Addr and S_Addr != 0, S = D in the same cycle; likewise for T. Both ports may bypass simultaneously.
- Scoreboard per clock, evaluated in priority order:
  - sb_flush: all busy bits <= 0, busy_cnt <= 0; rsv_en and the writeback clear are ignored that cycle (data write still happens).
  - Otherwise, writeback clear: D_En with D_Addr != 0 clears busy[D_Addr].
  - Reserve: rsv_en with rsv_addr != 0 sets busy[rsv_addr]; if rsv_addr == D_Addr in the same cycle, the reserve wins (newer producer) and the bit stays 1.
  - Reserving register 0 has no effect; reserving an already-busy register leaves it busy (no double count).
  - busy_cnt always equals popcount(busy) after the edge; it is updated incrementally (+1, -1, 0) per the net bit change.
- Busy outputs: S_busy = busy[S_Addr] & (S_Addr != 0), masked to 0 when BYPASS=1 and the same-cycle write targets S_Addr (the value is forwarded). Same rule for T_busy. With BYPASS=0 no masking.

## Timing
- Read latency 0 cycles (combinational from address, and from D/D_En when bypassing).
- Write visible through array one cycle after the edge; visible same cycle only via bypass.
- Reservation visible on S_busy/T_busy/busy_cnt in the cycle after rsv_en is sampled.
- Writeback clear visible on busy outputs next cycle (same cycle when bypass masks it).
- reset asserted mid-operation clears state immediately, independent of clk; first write accepted on the first posedge after deassertion.
- busy_cnt range 0 to 2**ADDR_W - 1 (register 0 never busy); no overflow possible.

## Structure
- Package regfile_pkg: default DATA_W/ADDR_W constants and a function computing depth from ADDR_W.
- Sub-module regfile_scoreboard: busy vector, busy_cnt, flush/clear/reserve priority; top module holds array, write logic, bypass muxes and busy masking.

## Test plan
- Reset then write 0xDEADBEEF to r5; next cycle S_Addr=5 -> S=0xDEADBEEF; write 0x1234 to r0 -> T_Addr=0 reads 0.
- BYPASS=1: D_En=1, D_Addr=7, D=0xA5A5A5A5, S_Addr=T_Addr=7 same cycle -> S=T=0xA5A5A5A5; BYPASS=0 -> old value 0.
- rsv r3 -> next cycle S_Addr=3 gives S_busy=1, hazard=1, busy_cnt=1; writeback r3 -> busy clears, busy_cnt=0; during writeback cycle with BYPASS=1 S_busy=0.
- Same cycle rsv r9 and write r9 (r9 busy) -> r9 stays busy, data updated, busy_cnt unchanged; rsv r0 -> busy_cnt unchanged.
- Reserve r1..r31 -> busy_cnt=31; sb_flush with rsv_en on r4 -> busy_cnt=0, r4 not busy.
- Assert reset asynchronously mid-burst of writes -> S, T, busy_cnt go 0 without a clock edge.
